core_sequencer: RTL and testbench

- Multi-cycle control FSM for the RV32I embedded softcore.
- Each instruction runs fetch -> decode -> memory (loads/stores only) -> writeback.
- Owns the PC, the instruction register fed to the instruction decoder, and the instruction/data memory handshakes. Sequences register-file writes and PC updates from the decoder's control outputs.
- Traps on decoder exceptions and on memory timeouts.

---
 rtl/core_sequencer.sv | 126 ++++++++++++
 tb/tb_core_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle fetch/decode/mem/writeback control FSM for the RV32I softcore
module core_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        resetb,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  input  logic        dec_exception,
  input  logic        dec_is_load,
  input  logic        dec_is_store,
  input  logic        dec_regwrite,
  input  logic [31:0] pc_next,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  output logic        rf_we,
  output logic [31:0] pc,
  output logic [31:0] instret,
  output logic        trap,
  output logic [1:0]  trap_cause
);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_MEM, S_WB, S_TRAP} state_t;
  localparam bit          TO_EN   = (MEM_TIMEOUT != 0);
  localparam logic [31:0] TO_LAST = MEM_TIMEOUT - 1;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, inst_q, inst_d, instret_q, instret_d, cnt_q, cnt_d;
  logic        trap_q, trap_d;
  logic [1:0]  cause_q, cause_d;
  logic        timeout;
  // the last permitted wait cycle of a request has been reached without ready
  assign timeout = TO_EN && (cnt_q == TO_LAST);
  // next-state logic: sequencing, wait counting and trap capture
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    instret_d = instret_q;
    cnt_d     = cnt_q;
    trap_d    = trap_q;
    cause_d   = cause_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        cnt_d   = '0;
      end
      S_FETCH: begin
        if (imem_ready) begin
          inst_d  = imem_rdata;
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = 2'd2;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_DECODE: begin
        if (dec_exception) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = 2'd1;
        end else if (dec_is_load || dec_is_store) begin
          state_d = S_MEM;
          cnt_d   = '0;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (dmem_ready) begin
          state_d = S_WB;
        end else if (timeout) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = 2'd3;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_WB: begin
        pc_d      = pc_next;
        instret_d = instret_q + 32'd1;
        state_d   = S_FETCH;
        cnt_d     = '0;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
  end
  // state registers; reset aborts any outstanding request immediately
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      instret_q <= '0;
      cnt_q     <= '0;
      trap_q    <= 1'b0;
      cause_q   <= 2'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      instret_q <= instret_d;
      cnt_q     <= cnt_d;
      trap_q    <= trap_d;
      cause_q   <= cause_d;
    end
  end
  assign imem_req   = (state_q == S_FETCH);
  assign dmem_req   = (state_q == S_MEM);
  assign dmem_we    = dmem_req & dec_is_store;
  assign rf_we      = (state_q == S_WB) & dec_regwrite;
  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign inst       = inst_q;
  assign instret    = instret_q;
  assign trap       = trap_q;
  assign trap_cause = cause_q;
endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: random instruction stream against a scoreboard of expected retire/trap events
module tb_core_sequencer;
  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam int TO = 4;
  typedef struct {
    bit          is_trap;
    logic [1:0]  cause;
    logic [31:0] pc;
    logic [31:0] ir;
    int          lat, nim, nd, ndwe, nrf;
  } exp_t;
  logic clk = 0, resetb = 1;
  logic imem_req, imem_ready = 0, dmem_req, dmem_we, dmem_ready = 0, rf_we, trap;
  logic [31:0] imem_addr, imem_rdata = 0, inst, pc, instret, pc_next;
  logic [1:0] trap_cause;
  logic dec_exception, dec_is_load, dec_is_store, dec_regwrite;
  exp_t sb[$];
  int n_cmp = 0, n_bad = 0;
  logic [31:0] pc_m = RPC, ir_m = 0;
  bit armed = 0;
  always #5 clk = ~clk;
  function automatic bit f_ill(logic [31:0] w);
    return w[6:0] == 7'h7f || (w[6:0] == 7'h03 && w[14:12] == 3'b111);
  endfunction
  function automatic bit f_rw(logic [31:0] w);
    return w[6:0] != 7'h23 && w[11:7] != 5'd0;
  endfunction
  function automatic logic [31:0] f_next(logic [31:0] p, logic [31:0] w);
    return w[12] ? p + {{20{w[31]}}, w[31:20]} : p + 32'd4;
  endfunction
  assign dec_exception = f_ill(inst);
  assign dec_is_load   = inst[6:0] == 7'h03;
  assign dec_is_store  = inst[6:0] == 7'h23;
  assign dec_regwrite  = f_rw(inst);
  assign pc_next       = f_next(pc, inst);
  core_sequencer #(.RESET_PC(RPC), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .resetb(resetb), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .inst(inst),
    .dec_exception(dec_exception), .dec_is_load(dec_is_load), .dec_is_store(dec_is_store),
    .dec_regwrite(dec_regwrite), .pc_next(pc_next), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_ready(dmem_ready), .rf_we(rf_we), .pc(pc), .instret(instret), .trap(trap),
    .trap_cause(trap_cause)
  );
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask
  // reset values must appear asynchronously, without waiting for a clock edge
  always @(negedge resetb) begin
    #1;
    armed = 1;
    chk("rst_pc", pc, RPC);
    chk("rst_instret", instret, 0);
    chk("rst_inst", inst, 0);
    chk("rst_trap", {30'd0, trap_cause}, {31'd0, trap} & 0);
    chk("rst_trap_flag", {31'd0, trap}, 0);
    chk("rst_strobes", {28'd0, imem_req, dmem_req, dmem_we, rf_we}, 0);
  end
  // monitor: samples on the falling edge, pops an expectation on every retire or trap
  int cyc = 0, start = 0, rel = 0, nim = 0, nd = 0, ndwe = 0, nrf = 0;
  logic [31:0] prev_ir, tpc, tir;
  logic prev_trap = 0, prev_ireq = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!resetb || !armed) begin
      rel = 0;
      prev_trap = 0;
      prev_ireq = 0;
      prev_ir = instret;
    end else begin
      if (rel == 0) begin
        chk("idle_cycle_req", {31'd0, imem_req}, 0);
        rel = 1;
      end else if (rel == 1) begin
        chk("first_fetch_req", {31'd0, imem_req}, 1);
        chk("first_fetch_addr", imem_addr, RPC);
        rel = 2;
      end
      chk("imem_addr_eq_pc", imem_addr, pc);
      if (instret != prev_ir || (trap && !prev_trap)) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_event: got instret=%0h trap=%0b expected no event", instret, trap);
        end else begin
          e = sb.pop_front();
          chk("ev_trap", {31'd0, trap}, {31'd0, e.is_trap});
          chk("ev_cause", {30'd0, trap_cause}, {30'd0, e.cause});
          chk("ev_pc", pc, e.pc);
          chk("ev_instret", instret, e.ir);
          chk("ev_latency", cyc - start, e.lat);
          chk("ev_imem_cycles", nim, e.nim);
          chk("ev_dmem_cycles", nd, e.nd);
          chk("ev_dmem_we_cycles", ndwe, e.ndwe);
          chk("ev_rf_we_cycles", nrf, e.nrf);
        end
        tpc = pc;
        tir = instret;
      end else if (trap && prev_trap) begin
        chk("trap_freeze", {26'd0, imem_req, dmem_req, dmem_we, rf_we, pc != tpc, instret != tir}, 0);
      end
      if (imem_req && !prev_ireq) begin
        start = cyc;
        nim = 0; nd = 0; ndwe = 0; nrf = 0;
      end
      nim += int'(imem_req);
      nd += int'(dmem_req);
      ndwe += int'(dmem_we);
      nrf += int'(rf_we);
      prev_ir = instret;
      prev_trap = trap;
      prev_ireq = imem_req;
    end
    cyc++;
  end
  task automatic do_reset();
    sb.delete();
    resetb = 0;
    pc_m = RPC;
    ir_m = 0;
    repeat (2) @(posedge clk);
    #1 resetb = 1;
  endtask
  // one instruction: fetch with fw wait cycles, memory with mw wait cycles
  task automatic issue(input logic [31:0] w, input int fw, input int mw, input bit abort);
    exp_t e;
    bit mem;
    int k;
    mem = (w[6:0] == 7'h03 || w[6:0] == 7'h23) && !f_ill(w);
    e = '{is_trap: 1, cause: 0, pc: pc_m, ir: ir_m, lat: 0, nim: fw + 1, nd: 0, ndwe: 0, nrf: 0};
    if (fw >= TO) begin
      e.cause = 2; e.lat = TO; e.nim = TO;
    end else if (f_ill(w)) begin
      e.cause = 1; e.lat = fw + 2;
    end else if (mem && mw >= TO) begin
      e.cause = 3; e.lat = fw + 2 + TO; e.nd = TO;
      e.ndwe = (w[6:0] == 7'h23) ? TO : 0;
    end else begin
      e.is_trap = 0;
      pc_m = f_next(pc_m, w);
      ir_m = ir_m + 1;
      e.pc = pc_m; e.ir = ir_m;
      e.lat = fw + 3 + (mem ? mw + 1 : 0);
      e.nd = mem ? mw + 1 : 0;
      e.ndwe = (w[6:0] == 7'h23) ? e.nd : 0;
      e.nrf = int'(f_rw(w));
    end
    sb.push_back(e);
    k = 0;
    while (!imem_req && k < 20) begin @(posedge clk); #1; k++; end
    chk("fetch_start", {31'd0, imem_req}, 1);
    for (int i = 0; i <= fw && i < TO; i++) begin
      imem_ready = (i == fw);
      imem_rdata = (i == fw) ? w : $urandom;
      @(posedge clk); #1;
    end
    imem_ready = 0;
    imem_rdata = $urandom;
    if (mem && fw < TO) begin
      k = 0;
      while (!dmem_req && k < 5) begin @(posedge clk); #1; k++; end
      chk("mem_start", {31'd0, dmem_req}, 1);
      for (int i = 0; i <= mw && i < TO; i++) begin
        if (abort && i == 1) begin
          do_reset();
          return;
        end
        dmem_ready = (i == mw);
        @(posedge clk); #1;
      end
      dmem_ready = 0;
    end
    if (e.is_trap) begin
      k = 0;
      while (!trap && k < 40) begin @(posedge clk); #1; k++; end
      chk("trap_reached", {31'd0, trap}, 1);
      repeat (20) @(posedge clk);
      #1 do_reset();
    end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] w;
    int k, fw, mw;
    #1 resetb = 0;
    repeat (2) @(posedge clk);
    #1 resetb = 1;
    issue(32'h0010_0093, 0, 0, 0);
    issue({12'h010, 5'd2, 3'b010, 5'd5, 7'h03}, 0, 3, 0);
    issue({7'h0, 5'd3, 5'd2, 3'b010, 5'd0, 7'h23}, 0, 0, 0);
    issue({12'h7ff, 5'd1, 3'b001, 5'd6, 7'h13}, 3, 0, 0);
    issue({12'h004, 5'd1, 3'b000, 5'd7, 7'h03}, 3, 3, 0);
    issue({25'h1234567, 7'h7f}, 0, 0, 0);
    issue({12'h004, 5'd1, 3'b111, 5'd7, 7'h03}, 1, 0, 0);
    issue(32'h0010_0093, 4, 0, 0);
    issue({7'h0, 5'd3, 5'd2, 3'b010, 5'd0, 7'h23}, 0, 4, 0);
    issue({12'h010, 5'd2, 3'b010, 5'd5, 7'h03}, 0, 3, 1);
    for (int n = 0; n < 150; n++) begin
      w = $urandom;
      k = $urandom_range(0, 15);
      w[6:0] = (k == 0) ? 7'h7f : (k <= 5) ? 7'h03 : (k <= 9) ? 7'h23 : 7'h13;
      if (k >= 2 && k <= 5) w[14:12] = 3'($urandom_range(0, 6));
      if (k == 1) w[14:12] = 3'b111;
      fw = ($urandom_range(0, 19) == 0) ? 4 + $urandom_range(0, 1) : $urandom_range(0, 3);
      mw = ($urandom_range(0, 19) == 0) ? 4 + $urandom_range(0, 1) : $urandom_range(0, 3);
      issue(w, fw, mw, 0);
    end
    repeat (6) @(posedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
